tile_judge: RTL and testbench

- Downstream consumer of the seven-row tile shifter; watches only the bottom row, where the player must hit the tile.
- Turns raw key presses into hit / wrong-press / miss decisions.
- Drives the shifter's correct_input to clear a hit tile, and keeps score, combo and lives.
- Owns the IDLE/PLAY/OVER game state used by display and control logic.

---
 rtl/tile_judge.sv | 160 ++++++++++++++++
 tb/tb_tile_judge.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/tile_judge.sv
// tile_judge: judges key presses against the bottom row of the tile shifter.
// Produces hit / wrong-press / miss decisions, keeps score, combo and lives,
// clears a hit tile via correct_input and owns the IDLE/PLAY/OVER game state.
module tile_judge #(
  parameter int LIVES   = 3,
  parameter int SCORE_W = 14,
  parameter int COMBO_W = 8
) (
  input  logic               clk,
  input  logic               resetn,
  input  logic               startn,
  input  logic               shift,
  input  logic [3:0]         keys,
  input  logic [2:0]         bottom_lane,
  output logic               correct_input,
  output logic [SCORE_W-1:0] score,
  output logic [COMBO_W-1:0] combo,
  output logic [2:0]         lives,
  output logic [1:0]         game_state,
  output logic               miss_pulse
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_PLAY = 2'd1;
  localparam logic [1:0] S_OVER = 2'd2;

  localparam logic [2:0] LIVES_INIT = 3'(LIVES);

  logic [3:0]         s1_q, s2_q, prev_q;
  logic [1:0]         state_q, state_d;
  logic [SCORE_W-1:0] score_q, score_d;
  logic [COMBO_W-1:0] combo_q, combo_d;
  logic [2:0]         lives_q, lives_d;
  logic               hp_q, hp_d;
  logic               ci_q, ci_d;
  logic               mp_q, mp_d;

  logic [3:0] press_vec;
  logic [3:0] lane_mask;
  logic       any_press, multi_press, hit, tile_present, lose;

  // Synchronise the asynchronous buttons and keep the previous sample for edge detection.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      s1_q   <= 4'b1111;
      s2_q   <= 4'b1111;
      prev_q <= 4'b1111;
    end else begin
      s1_q   <= keys;
      s2_q   <= s1_q;
      prev_q <= s2_q;
    end
  end

  // One bit per key that went high-to-low on the synchronised side.
  assign press_vec   = prev_q & ~s2_q;
  assign any_press   = |press_vec;
  assign multi_press = (press_vec & (press_vec - 4'd1)) != 4'd0;

  // Decode the bottom row into a one-hot lane mask; codes 0 and 5..7 are empty.
  always_comb begin
    lane_mask = 4'b0000;
    case (bottom_lane)
      3'd1:    lane_mask = 4'b0001;
      3'd2:    lane_mask = 4'b0010;
      3'd3:    lane_mask = 4'b0100;
      3'd4:    lane_mask = 4'b1000;
      default: lane_mask = 4'b0000;
    endcase
  end

  assign tile_present = |lane_mask;
  assign hit          = any_press && !multi_press && (press_vec == lane_mask);

  // Game FSM and judging; restart has priority over any judgement in the same cycle.
  always_comb begin
    state_d = state_q;
    score_d = score_q;
    combo_d = combo_q;
    lives_d = lives_q;
    hp_d    = hp_q;
    ci_d    = 1'b0;
    mp_d    = 1'b0;
    lose    = 1'b0;
    case (state_q)
      S_IDLE, S_OVER: begin
        if (!startn) begin
          state_d = S_PLAY;
          score_d = '0;
          combo_d = '0;
          lives_d = LIVES_INIT;
          hp_d    = 1'b0;
        end
      end
      S_PLAY: begin
        if (!startn) begin
          score_d = '0;
          combo_d = '0;
          lives_d = LIVES_INIT;
          hp_d    = 1'b0;
        end else if (hp_q) begin
          // The hit tile is still on the bottom row until the shifter clears it.
          if (!tile_present || shift) hp_d = 1'b0;
        end else if (multi_press) begin
          lose = 1'b1;
        end else if (any_press) begin
          if (hit) begin
            if (score_q != {SCORE_W{1'b1}}) score_d = score_q + 1'b1;
            if (combo_q != {COMBO_W{1'b1}}) combo_d = combo_q + 1'b1;
            // On a shift the tile leaves anyway; clearing would eat the next tile.
            if (!shift) begin
              ci_d = 1'b1;
              hp_d = 1'b1;
            end
          end else begin
            lose = 1'b1;
          end
        end else if (shift && tile_present) begin
          lose = 1'b1;
        end
        if (lose) begin
          lives_d = (lives_q != 3'd0) ? lives_q - 3'd1 : 3'd0;
          combo_d = '0;
          mp_d    = 1'b1;
          if (lives_q <= 3'd1) state_d = S_OVER;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Game state registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q <= S_IDLE;
      score_q <= '0;
      combo_q <= '0;
      lives_q <= LIVES_INIT;
      hp_q    <= 1'b0;
      ci_q    <= 1'b0;
      mp_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      score_q <= score_d;
      combo_q <= combo_d;
      lives_q <= lives_d;
      hp_q    <= hp_d;
      ci_q    <= ci_d;
      mp_q    <= mp_d;
    end
  end

  assign correct_input = ci_q;
  assign miss_pulse    = mp_q;
  assign score         = score_q;
  assign combo         = combo_q;
  assign lives         = lives_q;
  assign game_state    = state_q;

endmodule

// File: tb/tb_tile_judge.sv
// tb_tile_judge: directed game scenarios followed by random play, every cycle
// compared against a behavioural game model.
module tb_tile_judge;
  localparam int SCORE_W = 14;
  localparam int COMBO_W = 8;

  logic               clk = 1'b0;
  logic               resetn = 1'b0;
  logic               startn = 1'b1;
  logic               shift = 1'b0;
  logic [3:0]         keys = 4'hF;
  logic [2:0]         bottom_lane = 3'd0;
  logic               correct_input, miss_pulse;
  logic [SCORE_W-1:0] score;
  logic [COMBO_W-1:0] combo;
  logic [2:0]         lives;
  logic [1:0]         game_state;

  tile_judge #(.LIVES(3), .SCORE_W(SCORE_W), .COMBO_W(COMBO_W)) dut (
    .clk(clk), .resetn(resetn), .startn(startn), .shift(shift), .keys(keys),
    .bottom_lane(bottom_lane), .correct_input(correct_input), .score(score),
    .combo(combo), .lives(lives), .game_state(game_state), .miss_pulse(miss_pulse)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string tag, input int got, input int exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got %0d exp %0d @%0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: history of key samples taken at each clock edge,
  // game tracked as plain integers.
  logic [3:0] h1 = 4'hF, h2 = 4'hF, h3 = 4'hF;
  int m_state = 0, m_score = 0, m_combo = 0, m_lives = 3, m_hp = 0, m_ci = 0, m_mp = 0;

  task automatic reload();
    m_state = 1; m_score = 0; m_combo = 0; m_lives = 3; m_hp = 0;
  endtask

  task automatic model_step();
    logic [3:0] press;
    int n, l;
    bit tile, lose;
    if (!resetn) begin
      h1 = 4'hF; h2 = 4'hF; h3 = 4'hF;
      m_state = 0; m_score = 0; m_combo = 0; m_lives = 3; m_hp = 0; m_ci = 0; m_mp = 0;
      return;
    end
    // A press judged at this edge is a key low two samples ago after high three ago.
    press = h3 & ~h2;
    h3 = h2; h2 = h1; h1 = keys;
    n = $countones(press);
    l = int'(bottom_lane);
    tile = (l >= 1 && l <= 4);
    lose = 0;
    m_ci = 0; m_mp = 0;
    if (m_state != 1) begin
      if (!startn) reload();
    end else if (!startn) begin
      reload();
    end else if (m_hp != 0) begin
      if (!tile || shift) m_hp = 0;
    end else if (n > 1) begin
      lose = 1;
    end else if (n == 1) begin
      if (tile && press[l-1]) begin
        if (m_score < (1 << SCORE_W) - 1) m_score++;
        if (m_combo < (1 << COMBO_W) - 1) m_combo++;
        if (!shift) begin m_ci = 1; m_hp = 1; end
      end else lose = 1;
    end else if (shift && tile) begin
      lose = 1;
    end
    if (lose) begin
      if (m_lives > 0) m_lives--;
      m_combo = 0; m_mp = 1;
      if (m_lives == 0) m_state = 2;
    end
  endtask

  // One clock: drive on the falling edge, model the rising edge, compare just after.
  task automatic cyc(input logic [3:0] k, input logic sh, input logic [2:0] bl,
                     input logic st, input logic rs);
    @(negedge clk);
    keys = k; shift = sh; bottom_lane = bl; startn = st; resetn = rs;
    @(posedge clk);
    model_step();
    #1;
    chk("state", int'(game_state), m_state);
    chk("score", int'(score), m_score);
    chk("combo", int'(combo), m_combo);
    chk("lives", int'(lives), m_lives);
    chk("ci",    int'(correct_input), m_ci);
    chk("mp",    int'(miss_pulse), m_mp);
    chk("excl",  int'(correct_input & miss_pulse), 0);
  endtask

  initial begin
    // Reset values
    cyc(4'hF, 0, 0, 1, 0);
    cyc(4'hF, 0, 0, 1, 0);
    chk("rst_state", game_state, 0);
    chk("rst_lives", lives, 3);
    chk("rst_score", score, 0);
    // Start
    cyc(4'hF, 0, 0, 0, 1);
    chk("start_state", game_state, 1);
    chk("start_lives", lives, 3);
    chk("start_combo", combo, 0);
    cyc(4'hF, 0, 0, 1, 1);
    // Hit on lane 2 without shift: correct_input two edges after first low sample
    cyc(4'b1101, 0, 2, 1, 1);
    cyc(4'b1101, 0, 2, 1, 1);
    chk("hit_ci_early", correct_input, 0);
    cyc(4'b1101, 0, 2, 1, 1);
    chk("hit_ci", correct_input, 1);
    chk("hit_score", score, 1);
    chk("hit_combo", combo, 1);
    cyc(4'b1101, 0, 2, 1, 1);
    chk("hit_ci_one", correct_input, 0);
    // Pending hit: further presses on the same tile are ignored
    for (int i = 0; i < 3; i++) begin
      cyc(4'hF, 0, 2, 1, 1);
      cyc(4'b1101, 0, 2, 1, 1);
    end
    for (int i = 0; i < 3; i++) cyc(4'hF, 0, 2, 1, 1);
    chk("pend_score", score, 1);
    chk("pend_lives", lives, 3);
    cyc(4'hF, 0, 0, 1, 1);
    // Miss, then a shift over an empty row
    cyc(4'hF, 1, 3, 1, 1);
    chk("miss_mp", miss_pulse, 1);
    chk("miss_lives", lives, 2);
    chk("miss_combo", combo, 0);
    cyc(4'hF, 0, 0, 1, 1);
    chk("miss_mp_one", miss_pulse, 0);
    cyc(4'hF, 1, 0, 1, 1);
    chk("empty_lives", lives, 2);
    // Two keys together: wrong press
    cyc(4'b1010, 0, 1, 1, 1);
    cyc(4'b1010, 0, 1, 1, 1);
    cyc(4'b1010, 0, 1, 1, 1);
    chk("wrong_lives", lives, 1);
    chk("wrong_ci", correct_input, 0);
    for (int i = 0; i < 3; i++) cyc(4'hF, 0, 0, 1, 1);
    // Restart mid-play
    cyc(4'hF, 0, 0, 0, 1);
    chk("restart_lives", lives, 3);
    chk("restart_score", score, 0);
    // Hit on the shift cycle
    cyc(4'b0111, 0, 4, 1, 1);
    cyc(4'b0111, 0, 4, 1, 1);
    cyc(4'b0111, 1, 4, 1, 1);
    chk("shhit_score", score, 1);
    chk("shhit_ci", correct_input, 0);
    chk("shhit_lives", lives, 3);
    cyc(4'hF, 0, 0, 1, 1);
    chk("shhit_ci2", correct_input, 0);
    for (int i = 0; i < 2; i++) cyc(4'hF, 0, 0, 1, 1);
    // Three misses to game over
    for (int i = 0; i < 3; i++) cyc(4'hF, 1, 1, 1, 1);
    chk("over_lives", lives, 0);
    chk("over_state", game_state, 2);
    for (int i = 0; i < 6; i++) cyc(4'(i * 5), 1'(i), 3'(i % 5), 1, 1);
    chk("over_hold_lives", lives, 0);
    chk("over_hold_score", score, 1);
    cyc(4'hF, 0, 0, 0, 1);
    chk("over_restart_state", game_state, 1);
    chk("over_restart_lives", lives, 3);
    chk("over_restart_score", score, 0);
    // Reset mid-play
    cyc(4'hF, 1, 2, 1, 1);
    cyc(4'hF, 0, 0, 1, 0);
    chk("midrst_state", game_state, 0);
    chk("midrst_lives", lives, 3);
    chk("midrst_combo", combo, 0);

    // Random play
    begin
      logic [3:0] k;
      logic [2:0] bl;
      bl = 3'd0;
      for (int i = 0; i < 4000; i++) begin
        k = 4'hF;
        case ($urandom_range(0, 9))
          0, 1, 2: k[$urandom_range(0, 3)] = 1'b0;
          3:       k = 4'($urandom);
          default: k = 4'hF;
        endcase
        if ($urandom_range(0, 3) == 0) bl = 3'($urandom_range(0, 7));
        cyc(k, ($urandom_range(0, 4) == 0), bl,
            !($urandom_range(0, 29) == 0), !($urandom_range(0, 299) == 0));
      end
    end

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end
endmodule
